// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame levels and default timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DATA_BITS            = 8;
  localparam logic IDLE_LEVEL           = 1'b1;
  localparam logic START_LEVEL          = 1'b0;
  localparam int   CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo: synchronous circular byte buffer with occupancy count; read data is the
// current head, so a pop consumes the byte already presented on dout.
module byte_fifo #(
  parameter int  DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           push,
  input  logic           pop,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] level
);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard here as well so the buffer can never be corrupted by a careless caller.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign level = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// Back-to-back frames are separated by a single IDLE clock in which the next byte is popped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int  FIFO_DEPTH   = 16,
  localparam int PTR_W        = $clog2(FIFO_DEPTH)
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           clr_ovf,
  output logic           tx,
  output logic           busy,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] level,
  output logic           overflow
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  state_t            r_state,  w_state_next;
  logic [BAUD_W-1:0] r_baud,   w_baud_next;
  logic [BIT_W-1:0]  r_bit,    w_bit_next;
  logic [7:0]        r_shift,  w_shift_next;
  logic              r_tx,     w_tx_next;
  logic              r_overflow;
  logic              w_pop;
  logic              w_drop;
  logic              w_bit_end;
  logic [7:0]        w_dout;
`ifdef UART_TX_PARITY_EN
  logic              r_parity, w_parity_next;
`endif

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .n_reset (n_reset),
    .push    (wr_en),
    .pop     (w_pop),
    .din     (wr_data),
    .dout    (w_dout),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign w_pop     = (r_state == IDLE) && !empty;
  assign w_drop    = wr_en && full;
  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + BAUD_W'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        if (!empty) begin
          w_state_next = START;
          w_shift_next = w_dout;
          w_bit_next   = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^w_dout;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_baud_next  = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_next   = r_bit + BIT_W'(1);
            w_shift_next = r_shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
          w_baud_next  = '0;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
          w_baud_next  = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_baud_next  = '0;
      end
    endcase

    // The pin level follows the state being entered, so tx changes on the transition edge.
    case (w_state_next)
      START:   w_tx_next = START_LEVEL;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = w_parity_next;
`endif
      default: w_tx_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= IDLE_LEVEL;
      r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected bytes are queued at push time and a
// line monitor decodes every frame on tx and checks it bit-by-bit against the queue.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic          clock   = 1'b0;
  logic          n_reset = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          tx, busy, full, empty, overflow;
  logic [PW:0]   level;

  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;
  bit            mon_en = 1'b0;
  logic [7:0]    exp_q[$];
  int            start_q[$];

  logic [7:0]    mon_d;
  int            mon_bad;
  bit            mon_abort;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  // Reference frame: start(0), data LSB first, optional even parity, stop(1).
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == NB - 1) return 1'b1;
    return ^d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Line monitor: every falling edge of an idle line starts a frame.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
        start_q.push_back(cycle);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start at cycle %0d, required no frame", cycle);
          repeat (FRAME - 1) @(negedge clock);
        end else begin
          mon_d     = exp_q.pop_front();
          mon_bad   = 0;
          mon_abort = 1'b0;
          for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clock);
            if (!mon_en) begin
              mon_abort = 1'b1;
              break;
            end
            if (tx !== exp_bit(mon_d, i / CPB) || busy !== 1'b1) mon_bad++;
          end
          if (!mon_abort) begin
            checks++;
            if (mon_bad != 0) begin
              errors++;
              $display("FAIL frame: byte %02h got %0d bad samples required 0", mon_d, mon_bad);
            end else begin
              $display("frame %02h ok, started cycle %0d", mon_d, start_q[$]);
            end
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({"drain_", name}, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic quiet(input string name, input int ncyc);
    int lows;
    lows = 0;
    repeat (ncyc) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk(name, lows, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, g1, g2;
    logic [7:0] b;

    // Reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    n_reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;

    // Single byte: latency and frame length
    wr_en = 1'b1; wr_data = 8'h35; exp_q.push_back(8'h35);
    @(negedge clock);
    wr_en = 1'b0;
    chk("lat_level1", level, 1);
    chk("lat_tx_idle", tx, 1);
    @(negedge clock);
    chk("lat_tx_start", tx, 0);
    chk("lat_level0", level, 0);
    chk("lat_empty", empty, 1);
    n = (busy === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clock);
      if (busy === 1'b1) n++;
    end
    chk("busy_len", n, FRAME);
    drain("single");

    // Burst of three consecutive pushes
    start_q.delete();
    wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
    @(negedge clock);
    chk("burst_level_a", level, 1);
    wr_data = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clock);
    chk("burst_level_b", level, 1);
    wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clock);
    wr_en = 1'b0;
    chk("burst_level_peak", level, 2);
    drain("burst");
    chk("burst_empty", empty, 1);
    chk("burst_frames", start_q.size(), 3);
    g1 = -1; g2 = -1;
    if (start_q.size() >= 3) begin
      g1 = start_q[1] - start_q[0];
      g2 = start_q[2] - start_q[1];
    end
    chk("burst_gap1", g1, FRAME + 1);
    chk("burst_gap2", g2, FRAME + 1);

    // Overflow while the first frame blocks the FIFO
    wr_en = 1'b1; wr_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clock);
    wr_en = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'hB0 + 8'(i);
      if (i < DEPTH) exp_q.push_back(wr_data);
      @(negedge clock);
    end
    wr_en = 1'b0;
    chk("ovf_level", level, DEPTH);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
    @(negedge clock);
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_level_hold", level, DEPTH);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    chk("ovf_cleared2", overflow, 0);
    drain("ovf");
    chk("ovf_empty_end", empty, 1);
    quiet("ovf_no_extra", 2 * FRAME);

    // Reset during data bit 3
    mon_en = 1'b0;
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clock);
    wr_data = 8'hC3;
    @(negedge clock);
    wr_en = 1'b0;
    repeat (4 * CPB + 1) @(negedge clock);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_level", level, 1);
    n_reset = 1'b0;
    @(negedge clock);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1);
    n_reset = 1'b1;
    mon_en = 1'b1;
    quiet("midrst_no_frame", 3 * FRAME);

`ifdef UART_TX_PARITY_EN
    // Parity values for odd and even popcounts
    wr_en = 1'b1; wr_data = 8'h07; exp_q.push_back(8'h07);
    @(negedge clock);
    wr_en = 1'b0;
    drain("par07");
    wr_en = 1'b1; wr_data = 8'h03; exp_q.push_back(8'h03);
    @(negedge clock);
    wr_en = 1'b0;
    drain("par03");
`endif

    // Random bursts with random gaps, never more than the FIFO can hold
    for (int r = 0; r < 15; r++) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        wr_en = 1'b1; wr_data = b; exp_q.push_back(b);
        @(negedge clock);
        wr_en = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      drain("random");
    end
    chk("final_empty", empty, 1);
    chk("final_overflow", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit side of the board's serial link: accepts bytes from the processor's UART write path, buffers them in a FIFO and serialises them as 8N1 frames on the transmit pin.
- Complements the existing receive path, which delivers bytes to the processor.
- Sits between the control unit's uart write strobe / data-memory read data and the BT_UART_TX pin.
- Single clock domain (board clock).

Parameters:
- CLKS_PER_BIT, 434, board clocks per serial bit (50 MHz / 115200); minimum 2.
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clock  in  1  board clock; all logic on rising edge.
- n_reset  in  1  synchronous, active-low reset.
- wr_en  in  1  one-cycle push strobe.
- wr_data  in  8  byte to push.
- clr_ovf  in  1  clears overflow flag.
- tx  out  1  serial output, idle high.
- busy  out  1  frame in progress.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  PTR_W+1  current FIFO occupancy.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset: n_reset sampled low at an edge gives tx=1, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE, pointers and counters 0.
- Reset mid-frame aborts the frame immediately; tx returns high on the same edge.
- FIFO: circular buffer; pointers wrap modulo FIFO_DEPTH. full, empty and level are registered and derived from the count.
- Push: wr_en=1 and full=0 writes wr_data at the write pointer. level increments on the next edge.
- Push while full: the byte is dropped and overflow is set. This holds even if a pop happens in the same cycle, because full is judged on the registered count.
- overflow is cleared by clr_ovf=1. If clr_ovf and a dropped push occur in the same cycle, set wins.
- Simultaneous push and pop (not full): level unchanged.
- FSM states:
  - IDLE: tx=1, busy=0. If empty=0, pop the head into the shift register, go to START and clear the bit counter.
  - START: tx=0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT clocks.
  - PARITY: only with the optional feature.
  - STOP: tx=1 for CLKS_PER_BIT clocks, then IDLE.
- busy=1 in every state except IDLE.
- Latency: a push at edge N into an empty FIFO with FSM in IDLE makes level=1 after N. Pop and the START transition occur at edge N+1, so tx falls after N+1.
- Back-to-back frames: IDLE lasts exactly one clock between STOP and the next START (stop bit stretched by one clock). No other gaps.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reset on every state change.
- Pop only occurs in IDLE; the FIFO is never read while empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT clocks; frame is 11 bits (8E1).
- When undefined: no PARITY state or logic; frame is 10 bits (8N1).
- All ports are identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0;
  - default CLKS_PER_BIT.
- One natural sub-module: byte_fifo (parameterised synchronous FIFO with push/pop/full/empty/level), instantiated once. FSM and baud counter live in the top.

Test Plan:
- Reset: CLKS_PER_BIT=4, hold n_reset=0 for 3 clocks -> tx=1, busy=0, empty=1, level=0, overflow=0.
- Single byte: push 0x35 -> tx sequence 0,1,0,1,0,1,1,0,0,1 (start, LSB-first data, stop), each bit 4 clocks. busy high 40 clocks. Frame start exactly 2 edges after the push.
- Burst: push 0x00, 0xFF, 0xA5 on consecutive cycles -> level peaks at 2. Three frames transmitted in order, one idle clock between each; empty=1 after the third pop.
- Overflow: FIFO_DEPTH=4, transmitter blocked in first frame; push 6 bytes -> level=4, full=1, overflow=1, bytes 5–6 absent on tx. Then clr_ovf -> overflow=0.
- Reset mid-frame: assert n_reset=0 during DATA bit 3 -> tx=1, busy=0, level=0 after the edge. No residual frame after release.
- Parity build (UART_TX_PARITY_EN): push 0x07 -> parity bit 1 before stop, frame 44 clocks. Push 0x03 -> parity bit 0.
